// File: rtl/fwd_hazard_pkg.sv
// Shared constants for the forwarding / hazard-control block: operand-select
// encoding, default sizing and the select-width helper.
package fwd_hazard_pkg;

  localparam int NUM_SRC_DEF  = 2;
  localparam int NUM_STG_DEF  = 2;
  localparam int AW_DEF       = 5;
  localparam int MAX_PEND_DEF = 4;
  localparam int CNT_W_DEF    = 32;

  // Operand mux select: 0 reads the register file, FWD_STG_BASE+k takes stage k.
  localparam int FWD_RF       = 0;
  localparam int FWD_STG_BASE = 1;

  function automatic int fwd_sel_width(input int num_stg);
    return (num_stg < 1) ? 1 : $clog2(num_stg + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks registers awaiting a long-latency result (busy bits) and the number
// of operations outstanding in the long-latency unit.
module hazard_scoreboard
  import fwd_hazard_pkg::*;
#(
  parameter  int AW       = AW_DEF,
  parameter  int MAX_PEND = MAX_PEND_DEF,
  localparam int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic [AW-1:0]      issue_rd,
  input  logic               done_valid,
  input  logic [AW-1:0]      done_rd,
  output logic [2**AW-1:0]   busy_vec,
  output logic [PW-1:0]      pend_count
);

  logic [2**AW-1:0] busy_q, busy_d;
  logic [PW-1:0]    pend_q, pend_d;

  // Clear is applied before set so a same-cycle completion and reissue to one
  // register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (done_valid) busy_d[done_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pend_d = pend_q;
    if (issue_valid && !done_valid && (pend_q != PW'(MAX_PEND))) pend_d = pend_q + 1'b1;
    if (!issue_valid && done_valid && (pend_q != '0)) pend_d = pend_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  assign busy_vec   = busy_q;
  assign pend_count = pend_q;

`ifndef SYNTHESIS
  a_issue_when_full: assert property (@(posedge clk) disable iff (reset)
    !(issue_valid && !done_valid && (pend_q == PW'(MAX_PEND))));
  a_done_when_empty: assert property (@(posedge clk) disable iff (reset)
    !(done_valid && !issue_valid && (pend_q == '0)));
`endif

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Operand forwarding priority encoders, load-use / scoreboard / capacity stall
// generation, branch flushes and a saturating stall-cycle counter.
module fwd_hazard_scoreboard
  import fwd_hazard_pkg::*;
#(
  parameter  int NUM_SRC  = NUM_SRC_DEF,
  parameter  int NUM_STG  = NUM_STG_DEF,
  parameter  int AW       = AW_DEF,
  parameter  int MAX_PEND = MAX_PEND_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  localparam int SW       = fwd_sel_width(NUM_STG),
  localparam int PW       = $clog2(MAX_PEND + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC*AW-1:0] RsD,
  input  logic [AW-1:0]         RdD,
  input  logic                  RegWriteD,
  input  logic                  LongOpD,
  input  logic [NUM_SRC*AW-1:0] RsE,
  input  logic [AW-1:0]         RdE,
  input  logic                  LoadE,
  input  logic                  LongIssueE,
  input  logic                  PCSrcE,
  input  logic [NUM_STG*AW-1:0] RdStg,
  input  logic [NUM_STG-1:0]    RegWriteStg,
  input  logic                  LongDoneValid,
  input  logic [AW-1:0]         LongDoneRd,
  output logic [NUM_SRC*SW-1:0] FwdSel,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [2**AW-1:0]      BusyVec,
  output logic [PW-1:0]         PendCount,
  output logic [CNT_W-1:0]      StallCount
);

  logic             load_use, sb_haz, cap_haz, stall;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  hazard_scoreboard #(.AW(AW), .MAX_PEND(MAX_PEND)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(LongIssueE),
    .issue_rd   (RdE),
    .done_valid (LongDoneValid),
    .done_rd    (LongDoneRd),
    .busy_vec   (BusyVec),
    .pend_count (PendCount)
  );

  // Scanning oldest to youngest lets the youngest matching stage win.
  always_comb begin
    logic [AW-1:0] rs;
    logic [SW-1:0] sel;
    rs     = '0;
    sel    = '0;
    FwdSel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs  = RsE[i*AW +: AW];
      sel = SW'(FWD_RF);
      for (int k = NUM_STG - 1; k >= 0; k--) begin
        if (RegWriteStg[k] && (RdStg[k*AW +: AW] == rs) && (rs != '0))
          sel = SW'(FWD_STG_BASE + k);
      end
      FwdSel[i*SW +: SW] = sel;
    end
  end

  always_comb begin
    logic [AW-1:0] rs;
    rs       = '0;
    load_use = 1'b0;
    sb_haz   = RegWriteD && (RdD != '0) && BusyVec[RdD];
    for (int i = 0; i < NUM_SRC; i++) begin
      rs = RsD[i*AW +: AW];
      if (LoadE && (RdE != '0) && (RdE == rs)) load_use = 1'b1;
      if ((rs != '0) && BusyVec[rs]) sb_haz = 1'b1;
    end
    cap_haz = LongOpD && (PendCount == PW'(MAX_PEND));
    stall   = load_use | sb_haz | cap_haz;
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushD = PCSrcE;
  assign FlushE = stall | PCSrcE;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign StallCount = stall_count_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Scoreboard bench for fwd_hazard_scoreboard: driver pushes reference-model
// expectations per cycle, a negedge monitor pops and compares DUT outputs.
module tb_fwd_hazard_scoreboard;

  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int NSTG = 2;
  localparam int MAXP = 4;
  localparam int CW   = 32;
  localparam int SW   = 2;
  localparam int PW   = 3;
  localparam int NREG = 2**AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [AW-1:0]      rs_d [NSRC];
  logic [AW-1:0]      rs_e [NSRC];
  logic [AW-1:0]      rd_stg [NSTG];
  logic [AW-1:0]      rd_d, rd_e, done_rd;
  logic               rw_d, long_op_d, load_e, issue_e, pcsrc_e, done_v;
  logic [NSTG-1:0]    rws;

  logic [NSRC*AW-1:0] rsd_w, rse_w;
  logic [NSTG*AW-1:0] rdstg_w;
  logic [NSRC*SW-1:0] fwd_sel;
  logic               stall_f, stall_d, flush_d, flush_e;
  logic [NREG-1:0]    busy_vec;
  logic [PW-1:0]      pend_count;
  logic [CW-1:0]      stall_count;

  assign rsd_w   = {rs_d[1], rs_d[0]};
  assign rse_w   = {rs_e[1], rs_e[0]};
  assign rdstg_w = {rd_stg[1], rd_stg[0]};

  fwd_hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .RsD          (rsd_w),
    .RdD          (rd_d),
    .RegWriteD    (rw_d),
    .LongOpD      (long_op_d),
    .RsE          (rse_w),
    .RdE          (rd_e),
    .LoadE        (load_e),
    .LongIssueE   (issue_e),
    .PCSrcE       (pcsrc_e),
    .RdStg        (rdstg_w),
    .RegWriteStg  (rws),
    .LongDoneValid(done_v),
    .LongDoneRd   (done_rd),
    .FwdSel       (fwd_sel),
    .StallF       (stall_f),
    .StallD       (stall_d),
    .FlushD       (flush_d),
    .FlushE       (flush_e),
    .BusyVec      (busy_vec),
    .PendCount    (pend_count),
    .StallCount   (stall_count)
  );

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [NSRC*SW-1:0] fwd;
    logic               sf, sd, fd, fe;
    logic [NREG-1:0]    busy;
    logic [PW-1:0]      pend;
    logic [CW-1:0]      cnt;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0]   exp_q[$];
  bit              busy_m [NREG];
  int              pend_m;
  longint unsigned cnt_m;
  int              issued_q[$];
  int              n_vec = 0;
  int              n_mis = 0;

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) busy_m[r] = 1'b0;
    pend_m = 0;
    cnt_m  = 0;
    issued_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    reset = 1'b0; rd_d = '0; rd_e = '0; done_rd = '0;
    rw_d = 0; long_op_d = 0; load_e = 0; issue_e = 0; pcsrc_e = 0; done_v = 0;
    rws = '0;
    for (int i = 0; i < NSRC; i++) begin rs_d[i] = '0; rs_e[i] = '0; end
    for (int k = 0; k < NSTG; k++) rd_stg[k] = '0;
  endtask

  // Computes this cycle's expected outputs from the spec rules, queues them,
  // advances the model, then lets one clock edge pass.
  task automatic step();
    exp_t e;
    int   sel;
    bit   lu, sb, cap, st;
    e = '0;
    for (int i = 0; i < NSRC; i++) begin
      sel = 0;
      for (int k = 0; k < NSTG; k++)
        if (sel == 0 && rws[k] && rd_stg[k] == rs_e[i] && rs_e[i] != 0) sel = k + 1;
      e.fwd[i*SW +: SW] = SW'(sel);
    end
    lu = 0; sb = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (load_e && rd_e != 0 && rd_e == rs_d[i]) lu = 1;
      if (rs_d[i] != 0 && busy_m[rs_d[i]]) sb = 1;
    end
    if (rw_d && rd_d != 0 && busy_m[rd_d]) sb = 1;
    cap = long_op_d && (pend_m == MAXP);
    st  = lu || sb || cap;
    e.sf = st; e.sd = st; e.fd = pcsrc_e; e.fe = st || pcsrc_e;
    for (int r = 0; r < NREG; r++) e.busy[r] = busy_m[r];
    e.pend = PW'(pend_m);
    e.cnt  = CW'(cnt_m);
    exp_q.push_back(EW'(e));

    if (reset) begin
      model_clear();
    end else begin
      if (st && cnt_m < 64'hFFFF_FFFF) cnt_m++;
      if (done_v) busy_m[done_rd] = 1'b0;
      if (issue_e && rd_e != 0) busy_m[rd_e] = 1'b1;
      pend_m = pend_m + int'(issue_e) - int'(done_v);
      if (done_v && issued_q.size() > 0) void'(issued_q.pop_front());
      if (issue_e) issued_q.push_back(int'(rd_e));
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_t'(exp_q.pop_front());
      chk("fwd_sel",     64'(fwd_sel),     64'(e.fwd));
      chk("stall_f",     64'(stall_f),     64'(e.sf));
      chk("stall_d",     64'(stall_d),     64'(e.sd));
      chk("flush_d",     64'(flush_d),     64'(e.fd));
      chk("flush_e",     64'(flush_e),     64'(e.fe));
      chk("busy_vec",    64'(busy_vec),    64'(e.busy));
      chk("pend_count",  64'(pend_count),  64'(e.pend));
      chk("stall_count", 64'(stall_count), 64'(e.cnt));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear_in();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_clear();

    // reset state
    reset = 1'b1; step();
    reset = 1'b0;

    // forwarding priority
    rs_e[0] = 5; rs_e[1] = 5; rd_stg[0] = 5; rd_stg[1] = 5; rws = 2'b11; step();
    rws = 2'b10; step();
    rs_e[0] = 0; rs_e[1] = 0; step();
    clear_in();

    // load-use
    load_e = 1; rd_e = 7; rs_d[0] = 7; rs_d[1] = 3; step();
    load_e = 0; step();
    clear_in();

    // scoreboard RAW, release the cycle after completion
    issue_e = 1; rd_e = 9; step();
    clear_in(); rs_d[0] = 9;
    repeat (3) step();
    done_v = 1; done_rd = 9; step();
    done_v = 0; step();
    clear_in();
    // WAW
    issue_e = 1; rd_e = 9; step();
    clear_in(); rw_d = 1; rd_d = 9; step(); step();
    clear_in(); done_v = 1; done_rd = 9; step();
    clear_in(); rw_d = 1; rd_d = 9; step();
    clear_in();

    // capacity, then same-cycle done/issue to one register
    for (int r = 1; r <= 4; r++) begin issue_e = 1; rd_e = AW'(r); step(); end
    clear_in(); long_op_d = 1; step();
    clear_in(); issue_e = 1; rd_e = 1; done_v = 1; done_rd = 1; step();
    clear_in(); long_op_d = 1; rs_d[0] = 1; step();
    clear_in();
    while (issued_q.size() > 0) begin
      done_v = 1; done_rd = AW'(issued_q[0]); step();
    end
    clear_in();

    // taken branch with no hazard
    pcsrc_e = 1; step();
    clear_in();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      clear_in();
      for (int i = 0; i < NSRC; i++) begin
        rs_d[i] = AW'($urandom_range(0, 7));
        rs_e[i] = AW'($urandom_range(0, 7));
      end
      for (int k = 0; k < NSTG; k++) rd_stg[k] = AW'($urandom_range(0, 7));
      rws       = NSTG'($urandom_range(0, 3));
      rd_d      = AW'($urandom_range(0, 7));
      rw_d      = 1'($urandom_range(0, 1));
      long_op_d = 1'($urandom_range(0, 1));
      rd_e      = AW'($urandom_range(0, 7));
      load_e    = ($urandom_range(0, 3) == 0);
      pcsrc_e   = ($urandom_range(0, 7) == 0);
      done_v    = (issued_q.size() > 0) && ($urandom_range(0, 2) == 0);
      done_rd   = done_v ? AW'(issued_q[0]) : AW'($urandom_range(0, 31));
      issue_e   = ($urandom_range(0, 2) == 0) && (pend_m < MAXP || done_v);
      step();
    end

    // reset in the middle of activity
    clear_in(); issue_e = 1; rd_e = 12; step();
    clear_in(); issue_e = 1; rd_e = 13; rs_d[0] = 12; step();
    clear_in(); reset = 1; rs_d[0] = 12; step();
    clear_in(); rs_d[0] = 12; rs_d[1] = 13; step();
    clear_in(); step();

    repeat (3) @(negedge clk);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
